// File: rtl/fx3_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fx3_uart_pkg
// Purpose  : Shared constants and FSM state type for the FX3 UART TX/RX pair.
//            Both directions derive bit timing from the same oversample ratio,
//            so a single CLK_DIVISOR setting gives one baud rate for the link.
// Contents : OVERSAMPLE  - oversample ticks per bit period
//            DATA_BITS   - payload bits per 8N1 frame
//            uart_state_t- frame sequencing states
// Revision : 1.0 - initial release
// ============================================================================
package fx3_uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_t;

endpackage : fx3_uart_pkg
`default_nettype wire

// File: rtl/sync_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_byte_fifo
// Purpose  : Single-clock byte FIFO with first-word-fall-through read data.
//            Pointers carry one extra MSB so full and empty are told apart
//            without a separate counter.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            wr_en, wr_data      - write strobe (ignored when full) and byte
//            rd_en, rd_data      - pop strobe (ignored when empty); rd_data
//                                  always shows the head entry
//            full, empty, level  - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module sync_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_wr;
  logic        w_rd;

  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  // Storage is not reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level   = r_wr_ptr - r_rd_ptr;

endmodule : sync_byte_fifo
`default_nettype wire

// File: rtl/fx3_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fx3_uart_tx_fifo
// Purpose  : Buffered 8N1 UART transmitter for the FX3 control link. Bytes
//            enter a small FIFO over a valid/ready handshake and are sent
//            LSB first on uart_tx. One bit lasts OVERSAMPLE*CLK_DIVISOR clocks.
// Ports    : clk, reset     - system clock, synchronous active-high reset
//            tx_data        - byte to send
//            tx_data_valid  - tx_data is valid this cycle
//            tx_data_ready  - FIFO can take a byte this cycle
//            uart_tx        - registered serial line, idle high
//            tx_busy        - frame sequencing in progress
//            fifo_level     - bytes currently held in the FIFO
// Revision : 1.0 - initial release
// ============================================================================
module fx3_uart_tx_fifo
  import fx3_uart_pkg::*;
#(
  parameter int CLK_DIVISOR = 54,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TICK_W = (CLK_DIVISOR > 1) ? $clog2(CLK_DIVISOR) : 1;
  localparam int OS_W   = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] C_TICK_MAX = TICK_W'(CLK_DIVISOR - 1);
  localparam logic [OS_W-1:0]   C_OS_MAX   = OS_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        C_BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_t       r_state;
  uart_state_t       w_state_next;
  logic [TICK_W-1:0] r_tick;
  logic [OS_W-1:0]   r_os;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shreg;
  logic [7:0]        w_shreg_next;
  logic              r_uart_tx;
  logic              w_tx_next;
  logic              r_busy;

  logic              w_full;
  logic              w_empty;
  logic [7:0]        w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_bit_end;

  // --------------------------------------------------------------------------
  // Byte FIFO
  // --------------------------------------------------------------------------
  assign tx_data_ready = !w_full && !reset;
  assign w_push        = tx_data_valid && tx_data_ready;
  assign w_pop         = (r_state == LOAD);

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_push),
    .wr_data (tx_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  // Last clock of the current bit period.
  assign w_bit_end = (r_tick == C_TICK_MAX) && (r_os == C_OS_MAX);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (!w_empty) w_state_next = LOAD;
      LOAD:  w_state_next = START;
      START: if (w_bit_end) w_state_next = DATA;
      DATA:  if (w_bit_end && (r_bit_cnt == C_BIT_LAST)) w_state_next = STOP;
      STOP:  if (w_bit_end) w_state_next = w_empty ? IDLE : LOAD;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. The line register is loaded from the state being
  // entered, so uart_tx changes on the same edge as the state.
  // --------------------------------------------------------------------------
  always_comb begin
    w_shreg_next = r_shreg;
    if (r_state == LOAD) begin
      w_shreg_next = w_head;
    end else if ((r_state == DATA) && w_bit_end) begin
      w_shreg_next = {1'b0, r_shreg[7:1]};
    end

    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shreg_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Divider, bit counter and shift register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick    <= '0;
      r_os      <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else begin
      r_shreg <= w_shreg_next;
      if (r_state == LOAD) begin
        r_tick    <= '0;
        r_os      <= '0;
        r_bit_cnt <= '0;
      end else if (r_state != IDLE) begin
        if (r_tick == C_TICK_MAX) begin
          r_tick <= '0;
          r_os   <= (r_os == C_OS_MAX) ? '0 : r_os + 1'b1;
        end else begin
          r_tick <= r_tick + 1'b1;
        end
        // Wraps back to 0 after the eighth data bit, ready for the next frame.
        if ((r_state == DATA) && w_bit_end) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_uart_tx <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_uart_tx <= w_tx_next;
      r_busy    <= (w_state_next != IDLE);
    end
  end

  assign uart_tx = r_uart_tx;
  assign tx_busy = r_busy;

endmodule : fx3_uart_tx_fifo
`default_nettype wire

// File: tb/tb_fx3_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fx3_uart_tx_fifo
// Purpose  : Self-checking bench for fx3_uart_tx_fifo with CLK_DIVISOR=2
//            (32 clocks per bit) and FIFO_DEPTH=4. Accepted bytes are queued
//            as expected values; a line monitor decodes each frame at mid-bit
//            and compares it against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fx3_uart_tx_fifo;

  localparam int CLK_DIVISOR = 2;
  localparam int FIFO_DEPTH  = 4;
  localparam int BIT_CLKS    = 16 * CLK_DIVISOR;
  localparam int FRAME_CLKS  = 10 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_data_ready;
  logic       uart_tx;
  logic       tx_busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];

  // Line monitor state
  int         cyc = 0;
  bit         rst_seen = 1'b0;
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;
  int         last_fall = -1;
  bit         gap_chk = 1'b0;

  fx3_uart_tx_fifo #(
    .CLK_DIVISOR (CLK_DIVISOR),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .uart_tx       (uart_tx),
    .tx_busy       (tx_busy),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) rst_seen = 1'b1;
  end

  // Frame decoder: detection negedge is offset 0; bit n is sampled at 16+32*n.
  always @(negedge clk) begin
    if (rst_seen) begin
      rst_seen   = 1'b0;
      mon_active = 1'b0;
      last_fall  = -1;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_byte   = 8'h00;
        if (gap_chk && last_fall >= 0) begin
          checks++;
          if ((cyc - last_fall) !== FRAME_CLKS + 1) begin
            errors++;
            $display("FAIL frame_gap: fall-to-fall %0d clocks, expected %0d", cyc - last_fall, FRAME_CLKS + 1);
          end
        end
        last_fall = cyc;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == BIT_CLKS / 2) begin
        checks++;
        if (uart_tx !== 1'b0) begin
          errors++;
          $display("FAIL start_bit: line %b, expected 0", uart_tx);
        end
      end else if (mon_cnt > BIT_CLKS / 2 && ((mon_cnt - BIT_CLKS / 2) % BIT_CLKS) == 0) begin
        int idx;
        idx = (mon_cnt - BIT_CLKS / 2) / BIT_CLKS;
        if (idx <= 8) begin
          mon_byte[idx-1] = uart_tx;
        end else begin
          mon_active = 1'b0;
          checks++;
          if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit: line %b, expected 1", uart_tx);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_byte: got 0x%02h, expected no frame", mon_byte);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (mon_byte !== e) begin
              errors++;
              $display("FAIL rx_byte: got 0x%02h, expected 0x%02h", mon_byte, e);
            end
          end
        end
      end
    end
  end

  // Entered at a negedge; leaves valid high so consecutive calls push on
  // consecutive cycles. Returns at the negedge after the accepting edge.
  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    tx_data       = b;
    tx_data_valid = 1'b1;
    while (!tx_data_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_data_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready %b, expected 1 within 2000 clocks", tx_data_ready);
    end else begin
      exp_q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy !== 1'b0 || fifo_level !== 3'd0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_busy !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL idle_timeout: busy %b level %0d, expected 0 and 0", tx_busy, fifo_level);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_missing: %0d bytes unsent, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_data_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b, expected 0", tx_data_ready);
    end
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++; $display("FAIL reset_uart_tx: got %b, expected 1", uart_tx);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b, expected 0", tx_busy);
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_level: got %0d, expected 0", fifo_level);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (tx_data_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b, expected 1", tx_data_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    push_byte(8'hA5);             // accepted at edge k, now just after k
    tx_data_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd1 || tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_k: level %0d busy %b tx %b, expected 1 0 1", fifo_level, tx_busy, uart_tx);
    end
    @(negedge clk);               // after k+1 (LOAD)
    checks++;
    if (fifo_level !== 3'd1 || tx_busy !== 1'b1 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_load: level %0d busy %b tx %b, expected 1 1 1", fifo_level, tx_busy, uart_tx);
    end
    @(negedge clk);               // after k+2 (START)
    checks++;
    if (fifo_level !== 3'd0 || uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL single_start: level %0d tx %b, expected 0 0", fifo_level, uart_tx);
    end
    repeat (FRAME_CLKS - 1) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b1 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_last_stop: busy %b tx %b, expected 1 1", tx_busy, uart_tx);
    end
    @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_end: busy %b tx %b, expected 0 1", tx_busy, uart_tx);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    last_fall = -1;
    gap_chk   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i));
    end
    tx_data_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL b2b_level: got %0d, expected 3", fifo_level);
    end
    wait_idle();
    gap_chk = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc;
    int early;
    acc   = 0;
    early = 0;
    tx_data       = 8'h10;
    tx_data_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (tx_data_ready) begin
        exp_q.push_back(tx_data);
        acc++;
        @(negedge clk);
        tx_data = tx_data + 8'd1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (acc !== FIFO_DEPTH + 1) begin
      errors++;
      $display("FAIL capacity: accepted %0d, expected %0d", acc, FIFO_DEPTH + 1);
    end
    for (int i = 0; i < 290; i++) begin
      if (tx_data_ready) early++;
      @(negedge clk);
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL ready_while_full: ready seen %0d cycles, expected 0", early);
    end
    tx_data_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_simultaneous();
    push_byte(8'hA1);
    push_byte(8'hB2);             // now in the LOAD cycle
    checks++;
    if (fifo_level !== 3'd2 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_load: level %0d busy %b, expected 2 1", fifo_level, tx_busy);
    end
    push_byte(8'hC3);             // pushed on the same edge as the pop
    tx_data_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd2 || uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL simul_level: level %0d tx %b, expected 2 0", fifo_level, uart_tx);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    int n;
    push_byte(8'h5A);
    push_byte(8'h69);
    push_byte(8'h7E);
    tx_data_valid = 1'b0;
    n = 0;
    while (uart_tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (BIT_CLKS / 2 + 5 * BIT_CLKS) @(negedge clk);   // middle of data bit 4
    checks++;
    if (fifo_level !== 3'd2) begin
      errors++;
      $display("FAIL mid_level: got %0d, expected 2", fifo_level);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_data_ready !== 1'b0) begin
      errors++; $display("FAIL mid_ready: got %b, expected 0", tx_data_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (uart_tx !== 1'b1 || fifo_level !== 3'd0 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tx %b level %0d busy %b, expected 1 0 0", uart_tx, fifo_level, tx_busy);
    end
    exp_q.delete();
    @(negedge clk);
    push_byte(8'h3C);
    tx_data_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fx3_uart_tx_fifo
`default_nettype wire
